// File: rtl/prog_uart_loader.sv
// Serial program loader: receives UART 8N1 bytes, reads a 16-bit little-endian
// word count, then assembles 32-bit little-endian words and writes them to
// consecutive program-memory word addresses while holding the CPU in reset.
module prog_uart_loader #(
  parameter int CLK_DIV = 10416,
  parameter int ADDR_W  = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  input  logic              start_pg,
  output logic              upg_wen,
  output logic [ADDR_W-1:0] upg_addr,
  output logic [31:0]       upg_data,
  output logic              upg_done,
  output logic              upg_err,
  output logic              cpu_hold
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] BIT_TICKS  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_TICKS = CNT_W'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, DONE} ld_state_t;

  // Synchronizer stages: _p1 is the usable value, _p2 is its one-cycle-old copy
  logic rx_p0, rx_p1, rx_p2;
  logic start_p0, start_p1, start_p2;
  logic start_rise;

  // Byte receiver state
  rx_state_t        rx_state, rx_state_n;
  logic [CNT_W-1:0] tick_cnt, tick_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       rx_byte, rx_byte_n;
  logic             byte_vld, byte_vld_n;
  logic             frame_err, frame_err_n;

  // Loader state
  ld_state_t         ld_state, ld_state_n;
  logic [15:0]       words_left, words_left_n;
  logic [15:0]       hdr_count;
  logic [1:0]        byte_idx, byte_idx_n;
  logic [31:0]       word, word_n;
  logic              wen_n;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]       data_n;
  logic              done_n, err_n, hold_n;

  assign start_rise = start_p1 & ~start_p2;
  assign hdr_count  = {rx_byte, words_left[7:0]};

  // Two-flop synchronizers for rx (idle high) and start_pg, plus edge history
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_p0    <= 1'b1;
      rx_p1    <= 1'b1;
      rx_p2    <= 1'b1;
      start_p0 <= 1'b0;
      start_p1 <= 1'b0;
      start_p2 <= 1'b0;
    end else begin
      rx_p0    <= rx;
      rx_p1    <= rx_p0;
      rx_p2    <= rx_p1;
      start_p0 <= start_pg;
      start_p1 <= start_p0;
      start_p2 <= start_p1;
    end
  end

  // Receiver state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state  <= RX_IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      rx_byte   <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_state  <= rx_state_n;
      tick_cnt  <= tick_cnt_n;
      bit_idx   <= bit_idx_n;
      rx_byte   <= rx_byte_n;
      byte_vld  <= byte_vld_n;
      frame_err <= frame_err_n;
    end
  end

  // Receiver next state: half-bit start check, then one sample per bit period
  always_comb begin
    rx_state_n  = rx_state;
    tick_cnt_n  = tick_cnt;
    bit_idx_n   = bit_idx;
    rx_byte_n   = rx_byte;
    byte_vld_n  = 1'b0;
    frame_err_n = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_p2 && !rx_p1) begin
          rx_state_n = RX_START;
          tick_cnt_n = HALF_TICKS;
        end
      end
      RX_START: begin
        if (tick_cnt == '0) begin
          if (rx_p1) begin
            rx_state_n = RX_IDLE;
          end else begin
            rx_state_n = RX_DATA;
            tick_cnt_n = BIT_TICKS;
            bit_idx_n  = '0;
          end
        end else begin
          tick_cnt_n = tick_cnt - CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (tick_cnt == '0) begin
          rx_byte_n  = {rx_p1, rx_byte[7:1]};
          tick_cnt_n = BIT_TICKS;
          if (bit_idx == 3'd7) rx_state_n = RX_STOP;
          else                 bit_idx_n  = bit_idx + 3'd1;
        end else begin
          tick_cnt_n = tick_cnt - CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (tick_cnt == '0) begin
          byte_vld_n  = rx_p1;
          frame_err_n = ~rx_p1;
          rx_state_n  = RX_IDLE;
        end else begin
          tick_cnt_n = tick_cnt - CNT_W'(1);
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // Loader state and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ld_state   <= IDLE;
      words_left <= '0;
      byte_idx   <= '0;
      word       <= '0;
      upg_wen    <= 1'b0;
      upg_addr   <= '0;
      upg_data   <= '0;
      upg_done   <= 1'b0;
      upg_err    <= 1'b0;
      cpu_hold   <= 1'b0;
    end else begin
      ld_state   <= ld_state_n;
      words_left <= words_left_n;
      byte_idx   <= byte_idx_n;
      word       <= word_n;
      upg_wen    <= wen_n;
      upg_addr   <= addr_n;
      upg_data   <= data_n;
      upg_done   <= done_n;
      upg_err    <= err_n;
      cpu_hold   <= hold_n;
    end
  end

  // Loader next state: a start edge always restarts; framing errors abort
  always_comb begin
    ld_state_n   = ld_state;
    words_left_n = words_left;
    byte_idx_n   = byte_idx;
    word_n       = word;
    wen_n        = 1'b0;
    addr_n       = upg_addr + ADDR_W'(upg_wen);
    data_n       = upg_data;
    done_n       = upg_done;
    err_n        = upg_err;
    hold_n       = cpu_hold;
    if (start_rise) begin
      ld_state_n   = HDR0;
      words_left_n = '0;
      byte_idx_n   = '0;
      word_n       = '0;
      addr_n       = '0;
      done_n       = 1'b0;
      err_n        = 1'b0;
      hold_n       = 1'b1;
    end else begin
      case (ld_state)
        HDR0, HDR1, DATA: begin
          if (frame_err) begin
            ld_state_n = IDLE;
            err_n      = 1'b1;
            hold_n     = 1'b0;
            word_n     = '0;
          end else if (byte_vld) begin
            case (ld_state)
              HDR0: begin
                words_left_n = {8'h00, rx_byte};
                ld_state_n   = HDR1;
              end
              HDR1: begin
                words_left_n = hdr_count;
                byte_idx_n   = '0;
                if (hdr_count == 16'd0) begin
                  ld_state_n = DONE;
                  done_n     = 1'b1;
                  hold_n     = 1'b0;
                end else begin
                  ld_state_n = DATA;
                end
              end
              default: begin
                // Bytes shift in from the top, so after four the first is in [7:0]
                word_n = {rx_byte, word[31:8]};
                if (byte_idx == 2'd3) begin
                  wen_n        = 1'b1;
                  data_n       = {rx_byte, word[31:8]};
                  words_left_n = words_left - 16'd1;
                  byte_idx_n   = '0;
                end else begin
                  byte_idx_n = byte_idx + 2'd1;
                end
              end
            endcase
          end else if (ld_state == DATA && upg_wen && words_left == 16'd0) begin
            ld_state_n = DONE;
            done_n     = 1'b1;
            hold_n     = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_uart_loader.sv
// Self-checking bench for prog_uart_loader: table-driven load scenarios,
// randomized loads against a byte-stream reference model, and hand-written
// corner sequences (glitch, idle bytes, restart, reset mid-load).
module tb_prog_uart_loader;

  localparam int CLK_DIV = 8;
  localparam int ADDR_W  = 2;

  logic              clock;
  logic              reset;
  logic              rx;
  logic              start_pg;
  logic              upg_wen;
  logic [ADDR_W-1:0] upg_addr;
  logic [31:0]       upg_data;
  logic              upg_done;
  logic              upg_err;
  logic              cpu_hold;

  prog_uart_loader #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) dut (
    .clock    (clock),
    .reset    (reset),
    .rx       (rx),
    .start_pg (start_pg),
    .upg_wen  (upg_wen),
    .upg_addr (upg_addr),
    .upg_data (upg_data),
    .upg_done (upg_done),
    .upg_err  (upg_err),
    .cpu_hold (cpu_hold)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string           name;
    int              nbytes;
    logic [31:0][7:0] b;
    int              bad;       // index of the byte sent with stop=0, -1 for none
    logic            exp_done;
    logic            exp_err;
  } scn_t;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W+31:0] obs_q[$];
  logic [ADDR_W+31:0] exp_q[$];
  int cyc = 0, last_wen_cyc = -1, done_rise_cyc = -1, hold_fall_cyc = -1;
  logic done_q = 1'b0, hold_q = 1'b0;

  // Write monitor and edge timestamps, sampled away from the active edge
  always @(negedge clock) begin
    cyc++;
    if (upg_wen) begin
      obs_q.push_back({upg_addr, upg_data});
      last_wen_cyc = cyc;
    end
    if (upg_done && !done_q) done_rise_cyc = cyc;
    if (!cpu_hold && hold_q) hold_fall_cyc = cyc;
    done_q = upg_done;
    hold_q = cpu_hold;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic scn_t mk(input string nm, input int n, input logic [255:0] v,
                              input int bad, input logic d, input logic e);
    scn_t s;
    s.name = nm; s.nbytes = n; s.bad = bad; s.exp_done = d; s.exp_err = e;
    s.b = '0;
    for (int i = 0; i < n; i++) s.b[i] = v[8*(n-1-i) +: 8];
    return s;
  endfunction

  // Reference: walk the byte stream as a message (header count, then words)
  function automatic void ref_model(input scn_t s, output logic d, output logic e);
    int unsigned cnt = 0, widx = 0;
    int k;
    logic [31:0] w = '0;
    bit fin = 0;
    d = 1'b0; e = 1'b0;
    exp_q.delete();
    for (int i = 0; i < s.nbytes; i++) begin
      if (fin) continue;
      if (i == s.bad) begin e = 1'b1; fin = 1; continue; end
      if (i == 0) cnt = s.b[0];
      else if (i == 1) begin
        cnt = cnt + 256 * s.b[1];
        if (cnt == 0) begin d = 1'b1; fin = 1; end
      end else begin
        k = i - 2;
        w = w | (32'(s.b[i]) << (8 * (k % 4)));
        if (k % 4 == 3) begin
          exp_q.push_back({ADDR_W'(widx % (1 << ADDR_W)), w});
          widx++;
          w = '0;
          if (widx == cnt) begin d = 1'b1; fin = 1; end
        end
      end
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clock); rx = 1'b0;
    repeat (CLK_DIV) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CLK_DIV) @(negedge clock);
    end
    rx = stop;
    repeat (CLK_DIV) @(negedge clock);
    rx = 1'b1;
    repeat (2 * CLK_DIV) @(negedge clock);
  endtask

  task automatic pulse_start(input string nm);
    @(negedge clock); start_pg = 1'b1;
    repeat (4) @(negedge clock);
    chk({nm, ".start_hold"}, cpu_hold, 1'b1);
    chk({nm, ".start_done"}, upg_done, 1'b0);
    chk({nm, ".start_err"},  upg_err,  1'b0);
    chk({nm, ".start_addr"}, upg_addr, '0);
    start_pg = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic run_scn(input scn_t s, input logic d, input logic e);
    logic md, me;
    ref_model(s, md, me);
    obs_q.delete();
    pulse_start(s.name);
    for (int i = 0; i < s.nbytes; i++) send_byte(s.b[i], (i != s.bad));
    repeat (3 * CLK_DIV) @(negedge clock);
    chk({s.name, ".nwr"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s.addr%0d", s.name, i), obs_q[i][ADDR_W+31:32], exp_q[i][ADDR_W+31:32]);
      chk($sformatf("%s.data%0d", s.name, i), obs_q[i][31:0], exp_q[i][31:0]);
    end
    chk({s.name, ".done"}, upg_done, d);
    chk({s.name, ".err"},  upg_err,  e);
    chk({s.name, ".hold"}, cpu_hold, 1'b0);
    chk({s.name, ".wen"},  upg_wen,  1'b0);
    if (d && exp_q.size() > 0) begin
      chk({s.name, ".done_lat"}, done_rise_cyc, last_wen_cyc + 1);
      chk({s.name, ".hold_lat"}, hold_fall_cyc, last_wen_cyc + 1);
    end
  endtask

  scn_t tbl[6];
  scn_t rs;
  logic rd, re;
  int   rcnt;

  initial begin
    tbl[0] = mk("basic", 10, {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                              8'hEF, 8'hBE, 8'hAD, 8'hDE}, -1, 1'b1, 1'b0);
    tbl[1] = mk("zero", 2, {8'h00, 8'h00}, -1, 1'b1, 1'b0);
    tbl[2] = mk("frame", 5, {8'h01, 8'h00, 8'h11, 8'h22, 8'h33}, 4, 1'b0, 1'b1);
    tbl[3] = mk("wrap", 22, {8'h05, 8'h00, {4{8'h11}}, {4{8'h22}}, {4{8'h33}},
                             {4{8'h44}}, {4{8'h55}}}, -1, 1'b1, 1'b0);
    tbl[4] = mk("hdrerr", 1, {8'h03}, 0, 1'b0, 1'b1);
    tbl[5] = mk("late_err", 8, {8'h02, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4,
                                8'hB1, 8'hB2}, 7, 1'b0, 1'b1);

    reset = 1'b0; rx = 1'b1; start_pg = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst.wen",  upg_wen,  1'b0);
    chk("rst.addr", upg_addr, '0);
    chk("rst.data", upg_data, '0);
    chk("rst.done", upg_done, 1'b0);
    chk("rst.err",  upg_err,  1'b0);
    chk("rst.hold", cpu_hold, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    for (int t = 0; t < 6; t++) run_scn(tbl[t], tbl[t].exp_done, tbl[t].exp_err);

    // Randomized loads, some with a framing error injected
    for (int r = 0; r < 6; r++) begin
      rcnt = $urandom_range(1, 6);
      rs.name = $sformatf("rnd%0d", r);
      rs.nbytes = 2 + 4 * rcnt;
      rs.b = '0;
      rs.b[0] = 8'(rcnt);
      for (int i = 2; i < rs.nbytes; i++) rs.b[i] = 8'($urandom_range(0, 255));
      rs.bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rs.nbytes - 1)) : -1;
      rs.exp_done = 1'b0; rs.exp_err = 1'b0;
      ref_model(rs, rd, re);
      run_scn(rs, rd, re);
    end

    // Bytes arriving while idle after a completed load are ignored
    run_scn(tbl[0], 1'b1, 1'b0);
    obs_q.delete();
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1); send_byte(8'hDD, 1'b1);
    repeat (2 * CLK_DIV) @(negedge clock);
    chk("idle.nwr",  obs_q.size(), 0);
    chk("idle.done", upg_done, 1'b1);
    chk("idle.hold", cpu_hold, 1'b0);

    // A short low glitch on rx must not produce a byte
    pulse_start("glitch");
    @(negedge clock); rx = 1'b0;
    repeat (2) @(negedge clock); rx = 1'b1;
    repeat (5 * CLK_DIV) @(negedge clock);
    chk("glitch.err",  upg_err,  1'b0);
    chk("glitch.hold", cpu_hold, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    repeat (CLK_DIV) @(negedge clock);
    chk("glitch.done", upg_done, 1'b1);

    // Restart in the middle of a word
    pulse_start("pre_restart");
    send_byte(8'h02, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'hAA, 1'b1);
    run_scn(tbl[0], 1'b1, 1'b0);

    // Reset in the middle of the third data byte
    obs_q.delete();
    pulse_start("rstmid");
    send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    fork
      send_byte(8'h33, 1'b1);
      begin
        repeat (5 * CLK_DIV) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("rstmid.wen",  upg_wen,  1'b0);
        chk("rstmid.addr", upg_addr, '0);
        chk("rstmid.data", upg_data, '0);
        chk("rstmid.done", upg_done, 1'b0);
        chk("rstmid.err",  upg_err,  1'b0);
        chk("rstmid.hold", cpu_hold, 1'b0);
      end
    join
    repeat (5) @(negedge clock);
    chk("rstmid.nwr", obs_q.size(), 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    run_scn(tbl[0], 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_uart_loader.md
# prog_uart_loader

Serial program loader that writes the instruction memory read by the fetch stage. It receives UART 8N1 bytes, assembles them into 32-bit little-endian words, and issues one write per word at consecutive word addresses of the program memory write port. It holds the CPU in reset for the whole load. It sits between the board RX pin and the write side of the program memory.

## Interface
- CLK_DIV, 10416: clock cycles per UART bit (≥4).
- ADDR_W, 14: word-address width of program memory.
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  UART serial input; idles high; asynchronous to clock.
- start_pg  in  1  level; a rising edge (sampled) starts a new load.
- upg_wen  out  1  program-memory write enable, one-cycle pulse per word.
- upg_addr  out  ADDR_W  word address for the current write.
- upg_data  out  32  write data.
- upg_done  out  1  high after a load completes; sticky until next start.
- upg_err  out  1  framing error seen; sticky until next start.
- cpu_hold  out  1  high while loading; the CPU must be kept in reset.

## Operation
- rx passes through a 2-flop synchronizer, whose reset value is 1. All byte logic uses the synchronized value.
- Byte receiver:
  - A start is detected on a 1→0 transition while the receiver is idle.
  - The start bit is re-sampled CLK_DIV/2 cycles later; if it reads 1, the receiver returns to idle (glitch).
  - 8 data bits are sampled LSB first, one every CLK_DIV cycles.
  - The stop bit is sampled CLK_DIV cycles after bit 7.
  - Stop = 1 gives a valid byte. Stop = 0 is a framing error.
- Loader FSM states: IDLE, HDR0, HDR1, DATA, DONE.
  - IDLE: cpu_hold = 0; received bytes are ignored. A start_pg rising edge moves to HDR0.
  - On every start_pg rising edge: clear upg_done and upg_err, set upg_addr = 0, set cpu_hold = 1.
  - HDR0: the first valid byte becomes count[7:0]; go to HDR1.
  - HDR1: the next byte becomes count[15:8]. If count = 0, go to DONE; otherwise go to DATA.
  - DATA: bytes fill word[7:0], [15:8], [23:16], [31:24] in order.
    - After the 4th byte, pulse upg_wen with upg_data = word and the current upg_addr.
    - upg_addr increments by 1 the cycle after the pulse, modulo 2^ADDR_W (it wraps; no error).
    - The words-remaining counter decrements. When it reaches 0, go to DONE.
  - DONE: upg_done = 1, cpu_hold = 0, then return to IDLE behaviour; upg_done stays high.
  - Framing error in HDR0/HDR1/DATA: set upg_err = 1, abort to IDLE, set cpu_hold = 0. upg_done stays 0. A partially assembled word is discarded and never written.
- A start_pg rising edge while in HDR0/HDR1/DATA restarts the load: byte and word counters clear, addr goes to 0, the state goes to HDR0. A byte that is mid-reception continues and is treated as the first header byte.
- Reset values: upg_wen 0, upg_addr 0, upg_data 0, upg_done 0, upg_err 0, cpu_hold 0; FSM in IDLE; receiver idle.

## Timing
- The byte-valid strobe is internal, one cycle long, in the cycle after the stop-bit sample.
- upg_wen asserts in the cycle after the 4th byte's valid strobe. upg_data and upg_addr are stable during that cycle.
- upg_addr updates one cycle after upg_wen. Back-to-back writes are at least 10·CLK_DIV·4 cycles apart, so there is no throughput hazard.
- upg_done and cpu_hold = 0 take effect in the cycle after the last upg_wen (or after the HDR1 strobe when count = 0).
- start_pg goes through a 2-flop synchronizer plus edge detection, giving 3 cycles from pin to effect. It is ignored while reset is low.
- reset low at any time: all outputs go to their reset values immediately (asynchronously). No write pulse is ever issued while reset is low.

## Test plan
- Basic load (CLK_DIV=8): start_pg, then bytes 02 00 | 78 56 34 12 | EF BE AD DE.
  - Required: upg_wen at addr 0 with data 12345678, then at addr 1 with data DEADBEEF.
  - upg_done=1 and cpu_hold=0 one cycle after the second write.
- Zero count: bytes 00 00 → no upg_wen; upg_done=1 after the 2nd byte.
- Framing error: start_pg, 01 00, 11 22, then a byte with stop=0.
  - Required: upg_err=1, cpu_hold=0, upg_done=0, no upg_wen.
- Glitch and idle: a 2-cycle low pulse on rx → no byte. Bytes sent while in IDLE → no write and no state change.
- Wraparound (ADDR_W=2): count 5, five words → writes at addr 0,1,2,3,0 in order; upg_done=1.
- Reset mid-load: reset low during the 3rd data byte of word 0.
  - Required: all outputs 0 immediately.
  - After release, a new start_pg and a full load write correctly from addr 0.
